ascii_uart_tx: RTL and testbench

- Serial transmitter for the 8-bit ASCII result byte (`'0'`–`'3'`, 8'h30–8'h33) produced by the minimum-index comparator stage.
- Sits directly downstream of that stage and drives the board's UART TX pin, so the winning index appears on a host terminal.
- Frame format: 8N1, LSB first, with an optional even-parity bit.
- Each frame starts on a single-cycle request handshake; `busy` and `done` are reported back to the controlling logic.

---
 rtl/ascii_uart_tx.sv | 128 ++++++++++++
 tb/tb_ascii_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ascii_uart_tx.sv
// 8N1 UART transmitter for the ASCII result byte, LSB first.
// Define ASCII_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef ASCII_UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;
`ifdef ASCII_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_end = (baud_cnt == CNT_LAST);

    // tx is loaded one bit ahead at each boundary so the pin is a plain register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ASCII_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (send) begin
                        shreg      <= data_in;
                        baud_cnt   <= '0;
                        bit_idx    <= 3'd0;
                        state      <= START;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
`ifdef ASCII_UART_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef ASCII_UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef ASCII_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx at CLKS_PER_BIT=4; frame length follows ASCII_UART_TX_PARITY_EN.
module tb_ascii_uart_tx;

    localparam int C = 4;
`ifdef ASCII_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] EXP30 = {1'b1, 1'b0, 8'h30, 1'b0};
    localparam logic [10:0] EXP31 = {1'b1, 1'b1, 8'h31, 1'b0};
    localparam logic [10:0] EXP33 = {1'b1, 1'b0, 8'h33, 1'b0};
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP30 = {1'b0, 1'b1, 8'h30, 1'b0};
    localparam logic [10:0] EXP31 = {1'b0, 1'b1, 8'h31, 1'b0};
    localparam logic [10:0] EXP33 = {1'b0, 1'b1, 8'h33, 1'b0};
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       send = 1'b0;
    logic       tx, busy, done;
    int         checks = 0;
    int         errors = 0;

    ascii_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .send(send),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Returns at the negedge after the accept edge (frame offset 0).
    task automatic start_frame(input logic [7:0] d, input logic hold);
        @(negedge clk);
        send    = 1'b1;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) send = 1'b0;
    endtask

    // Records one frame from offset 0 through offset NB*C+1; optionally drives inputs at mid_cycle.
    task automatic capture(input int mid_cycle, input logic mid_send, input logic [7:0] mid_data,
                           output logic [10:0] bits, output logic stable, output logic busy_ok,
                           output logic quiet, output logic tx_now, output logic busy_now,
                           output logic done_now, output logic tx_next, output logic busy_next,
                           output logic done_next);
        bits = '0; stable = 1'b1; busy_ok = 1'b1; quiet = 1'b1;
        for (int k = 0; k < NB * C; k++) begin
            if (k % C == 0) bits[k / C] = tx;
            else if (tx !== bits[k / C]) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) quiet = 1'b0;
            if (k == mid_cycle) begin
                send    = mid_send;
                data_in = mid_data;
            end else if (mid_cycle >= 0 && k == mid_cycle + 1) begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        tx_now = tx; busy_now = busy; done_now = done;
        @(negedge clk);
        tx_next = tx; busy_next = busy; done_next = done;
    endtask

    task automatic test_reset();
        send = 1'b1;
        data_in = 8'h31;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst  = 1'b0;
        send = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({tx, busy, done} !== 3'b100) begin
            errors++; $display("FAIL reset_idle got %b want 100", {tx, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [10:0] bits;
        logic stable, busy_ok, quiet, tx_now, busy_now, done_now, tx_next, busy_next, done_next;
        start_frame(8'h30, 1'b0);
        capture(-1, 1'b0, 8'h00, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP30) begin errors++; $display("FAIL basic_bits got %b want %b", bits, EXP30); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL basic_bit_width got %b want 1", stable); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy_high got %b want 1", busy_ok); end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL basic_early_done got %b want 1", quiet); end
        checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got %b want 1", done_now); end
        checks++; if (busy_now !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", busy_now); end
        checks++; if (tx_now !== 1'b1) begin errors++; $display("FAIL basic_tx_end got %b want 1", tx_now); end
        checks++; if (done_next !== 1'b0) begin errors++; $display("FAIL basic_done_clear got %b want 0", done_next); end
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        logic stable, busy_ok, quiet, tx_now, busy_now, done_now, tx_next, busy_next, done_next;
        start_frame(8'h31, 1'b0);
        capture(-1, 1'b0, 8'h00, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP31) begin errors++; $display("FAIL parity31_bits got %b want %b", bits, EXP31); end
        checks++; if (done_now !== 1'b1 || quiet !== 1'b1) begin
            errors++; $display("FAIL parity31_done_time got %b%b want 11", done_now, quiet);
        end
        start_frame(8'h33, 1'b0);
        capture(-1, 1'b0, 8'h00, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP33) begin errors++; $display("FAIL parity33_bits got %b want %b", bits, EXP33); end
        checks++; if (done_now !== 1'b1 || quiet !== 1'b1) begin
            errors++; $display("FAIL parity33_done_time got %b%b want 11", done_now, quiet);
        end
    endtask

    task automatic test_busy_reject();
        logic [10:0] bits;
        logic stable, busy_ok, quiet, tx_now, busy_now, done_now, tx_next, busy_next, done_next;
        logic idle_ok;
        start_frame(8'h30, 1'b0);
        capture(10, 1'b1, 8'h32, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP30) begin errors++; $display("FAIL reject_bits got %b want %b", bits, EXP30); end
        checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL reject_done got %b want 1", done_now); end
        idle_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if ({tx, busy, done} !== 3'b100) idle_ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (idle_ok !== 1'b1) begin errors++; $display("FAIL reject_no_second_frame got %b want 1", idle_ok); end
    endtask

    task automatic test_input_stability();
        logic [10:0] bits;
        logic stable, busy_ok, quiet, tx_now, busy_now, done_now, tx_next, busy_next, done_next;
        start_frame(8'h30, 1'b0);
        capture(2, 1'b0, 8'hFF, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP30) begin errors++; $display("FAIL stable_bits got %b want %b", bits, EXP30); end
        data_in = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        logic stable, busy_ok, quiet, tx_now, busy_now, done_now, tx_next, busy_next, done_next;
        start_frame(8'h31, 1'b1);
        capture(-1, 1'b0, 8'h00, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP31) begin errors++; $display("FAIL b2b_first_bits got %b want %b", bits, EXP31); end
        checks++; if (tx_now !== 1'b1 || bits[NB-1] !== 1'b1 || stable !== 1'b1) begin
            errors++; $display("FAIL b2b_gap_high got %b%b%b want 111", tx_now, bits[NB-1], stable);
        end
        checks++; if (tx_next !== 1'b0 || busy_next !== 1'b1) begin
            errors++; $display("FAIL b2b_next_start got %b%b want 01", tx_next, busy_next);
        end
        send = 1'b0;
        capture(-1, 1'b0, 8'h00, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP31) begin errors++; $display("FAIL b2b_second_bits got %b want %b", bits, EXP31); end
        checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", done_now); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        logic stable, busy_ok, quiet, tx_now, busy_now, done_now, tx_next, busy_next, done_next;
        logic idle_ok;
        start_frame(8'h30, 1'b0);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({tx, busy, done} !== 3'b100) begin
            errors++; $display("FAIL midrst_immediate got %b want 100", {tx, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if ({tx, busy, done} !== 3'b100) idle_ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (idle_ok !== 1'b1) begin errors++; $display("FAIL midrst_no_done got %b want 1", idle_ok); end
        start_frame(8'h33, 1'b0);
        capture(-1, 1'b0, 8'h00, bits, stable, busy_ok, quiet, tx_now, busy_now, done_now,
                tx_next, busy_next, done_next);
        checks++; if (bits !== EXP33) begin errors++; $display("FAIL midrst_refire_bits got %b want %b", bits, EXP33); end
        checks++; if (done_now !== 1'b1 || busy_ok !== 1'b1) begin
            errors++; $display("FAIL midrst_refire_done got %b%b want 11", done_now, busy_ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_busy_reject();
        test_input_stability();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
